// File: rtl/cla_adder_if.sv
// cla_adder_if: operand/result bundle for the registered carry-lookahead adder.
//
// Handshake: valid-only, with no backpressure. The adder accepts a/b/c on every
// rising edge where in_valid=1. Exactly one cycle later it presents the result
// on sum/carry with out_valid=1. When out_valid=0, sum/carry keep the last result.
//
// Signals:
//   a, b      WIDTH  unsigned operands        (master -> slave)
//   c         1      carry-in                 (master -> slave)
//   in_valid  1      qualifies a/b/c          (master -> slave)
//   sum       WIDTH  registered sum           (slave -> master)
//   carry     1      registered carry-out     (slave -> master)
//   out_valid 1      registered result valid  (slave -> master)
interface cla_adder_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             out_valid;

  modport master (
    output a, b, c, in_valid,
    input  sum, carry, out_valid
  );

  modport slave (
    input  a, b, c, in_valid,
    output sum, carry, out_valid
  );
endinterface

// File: rtl/cla_adder.sv
// cla_adder: registered WIDTH-bit carry-lookahead adder, {carry,sum} = a + b + c.
// The adder uses per-bit generate/propagate terms and 4-bit lookahead groups.
// Group carries chain from one group to the next. The result is captured on the
// rising clk edge. There is no combinational path from the inputs to the outputs.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; clears sum, carry and out_valid
//   bus  cla_adder_if slave modport (a, b, c, in_valid in; sum, carry, out_valid out)
module cla_adder #(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  cla_adder_if.slave  bus
);
  localparam int GROUPS = WIDTH / 4;

  if ((WIDTH <= 0) || ((WIDTH % 4) != 0)) begin : g_bad_width
    $error("cla_adder: WIDTH must be a positive multiple of 4");
  end

  logic [WIDTH-1:0]  g;
  logic [WIDTH-1:0]  p;
  logic [WIDTH-1:0]  cbit;     // carry into each bit position
  logic [GROUPS-1:0] grp_g;
  logic [GROUPS-1:0] grp_p;
  logic [GROUPS:0]   gcin;     // carry into each group; gcin[GROUPS] is carry-out
  logic [WIDTH-1:0]  sum_next;
  logic              carry_next;

  always_comb begin
    logic [3:0] gk;
    logic [3:0] pk;
    logic       ci;
    g          = bus.a & bus.b;
    p          = bus.a ^ bus.b;
    cbit       = '0;
    grp_g      = '0;
    grp_p      = '0;
    gcin       = '0;
    gk         = '0;
    pk         = '0;
    ci         = 1'b0;
    gcin[0]    = bus.c;
    for (int k = 0; k < GROUPS; k++) begin
      gk = g[4*k +: 4];
      pk = p[4*k +: 4];
      ci = gcin[k];
      // Each in-group carry is a flat sum of products. No carry ripples inside a group.
      cbit[4*k]   = ci;
      cbit[4*k+1] = gk[0] | (pk[0] & ci);
      cbit[4*k+2] = gk[1] | (pk[1] & gk[0]) | (pk[1] & pk[0] & ci);
      cbit[4*k+3] = gk[2] | (pk[2] & gk[1]) | (pk[2] & pk[1] & gk[0])
                  | (pk[2] & pk[1] & pk[0] & ci);
      grp_g[k]    = gk[3] | (pk[3] & gk[2]) | (pk[3] & pk[2] & gk[1])
                  | (pk[3] & pk[2] & pk[1] & gk[0]);
      grp_p[k]    = &pk;
      gcin[k+1]   = grp_g[k] | (grp_p[k] & ci);
    end
    sum_next   = p ^ cbit;
    carry_next = gcin[GROUPS];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.sum       <= '0;
      bus.carry     <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.sum   <= sum_next;
        bus.carry <= carry_next;
      end
    end
  end
endmodule

// File: tb/tb_cla_adder.sv
module tb_cla_adder;
  logic clk;
  logic rst;

  cla_adder_if #(.WIDTH(4)) if4 ();
  cla_adder_if #(.WIDTH(8)) if8 ();

  cla_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  cla_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the expected registered state for each DUT.
  logic [4:0] m4;  // {carry,sum}
  logic       ov4;
  logic [8:0] m8;
  logic       ov8;

  // Scoreboard: the constant results listed for the 4-bit directed vectors.
  logic [4:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_outputs();
    check("w4_sum",   64'(if4.sum),       64'(m4[3:0]));
    check("w4_carry", 64'(if4.carry),     64'(m4[4]));
    check("w4_valid", 64'(if4.out_valid), 64'(ov4));
    check("w8_sum",   64'(if8.sum),       64'(m8[7:0]));
    check("w8_carry", 64'(if8.carry),     64'(m8[8]));
    check("w8_valid", 64'(if8.out_valid), 64'(ov8));
  endtask

  // Driver: at the falling edge, first check what the last rising edge produced.
  // Then apply the new inputs and advance the model.
  task automatic step(input logic [3:0] a4, input logic [3:0] b4, input logic c4, input logic v4,
                      input logic [7:0] a8, input logic [7:0] b8, input logic c8, input logic v8);
    @(negedge clk);
    check_outputs();
    if4.a = a4; if4.b = b4; if4.c = c4; if4.in_valid = v4;
    if8.a = a8; if8.b = b8; if8.c = c8; if8.in_valid = v8;
    if (v4) m4 = 5'(int'(a4) + int'(b4) + int'(c4));
    ov4 = v4;
    if (v8) m8 = 9'(int'(a8) + int'(b8) + int'(c8));
    ov8 = v8;
  endtask

  task automatic idle();
    step(4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] ta [6] = '{4'h1, 4'h2, 4'hA, 4'hF, 4'hD, 4'h5};
    logic [3:0] tb [6] = '{4'hC, 4'hF, 4'hD, 4'hF, 4'hD, 4'h3};
    logic       tc [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [4:0] te [6] = '{5'h0E, 5'h11, 5'h18, 5'h1F, 5'h1A, 5'h08};

    if4.a = '0; if4.b = '0; if4.c = 1'b0; if4.in_valid = 1'b0;
    if8.a = '0; if8.b = '0; if8.c = 1'b0; if8.in_valid = 1'b0;
    m4 = '0; ov4 = 1'b0; m8 = '0; ov8 = 1'b0;

    // Reset state
    rst = 1'b1;
    #1;
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed 4-bit vectors. The listed result must appear one edge after acceptance.
    for (int i = 0; i < 6; i++) exp_q.push_back(te[i]);
    for (int i = 0; i < 6; i++) begin
      step(ta[i], tb[i], tc[i], 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("w4_plan", 64'({if4.carry, if4.sum}), 64'(exp_q.pop_front()));
    end

    // Hold: drop in_valid and change the inputs. The 5+3 result must stay.
    step(4'h9, 4'h7, 1'b1, 1'b0, 8'h12, 8'h34, 1'b1, 1'b0);
    step(4'hF, 4'h1, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("w4_hold", 64'({if4.out_valid, if4.carry, if4.sum}), 64'({1'b0, 5'h08}));

    // Load 1111 / carry 1, then reset asynchronously between edges.
    step(4'hF, 4'hF, 1'b1, 1'b1, 8'hF0, 8'h0F, 1'b1, 1'b1);
    idle();
    @(posedge clk);
    #2;
    check("w4_pre_rst", 64'({if4.carry, if4.sum}), 64'(5'h1F));
    rst = 1'b1;
    #1;
    m4 = '0; ov4 = 1'b0; m8 = '0; ov8 = 1'b0;
    check("w4_async_rst", 64'({if4.out_valid, if4.carry, if4.sum}), 64'(0));
    check("w8_async_rst", 64'({if8.out_valid, if8.carry, if8.sum}), 64'(0));
    // Valid inputs presented during reset must be ignored.
    if4.a = 4'h7; if4.b = 4'h6; if4.c = 1'b1; if4.in_valid = 1'b1;
    if8.a = 8'h77; if8.b = 8'h66; if8.c = 1'b1; if8.in_valid = 1'b1;
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
    if4.in_valid = 1'b0;
    if8.in_valid = 1'b0;
    // The first add after release appears one edge later.
    step(4'h3, 4'h4, 1'b0, 1'b1, 8'h80, 8'h80, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("w4_post_rst", 64'({if4.out_valid, if4.carry, if4.sum}), 64'({1'b1, 5'h07}));

    // Full cross-group propagate chain in the 8-bit adder.
    step(4'hF, 4'h0, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("w8_chain", 64'({if8.carry, if8.sum}), 64'(9'h100));

    // Randomized traffic on both adders, with in_valid high about 3/4 of the time.
    for (int i = 0; i < 3000; i++) begin
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0),
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0));
    end
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cla_adder.md
Name: cla_adder

Overview:
- Registered N-bit carry-lookahead adder: computes sum = a + b + c with carry-out, using per-bit generate/propagate and 4-bit lookahead groups.
- The arithmetic core is combinational. Results are captured in output registers on the rising clock edge.
- General-purpose datapath primitive, used wherever a fast fixed-width add with carry-in/carry-out is needed.

Parameters:
- WIDTH, 4, operand width in bits; must be a positive multiple of 4 (one lookahead group per 4 bits).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- c  input  1  carry-in
- in_valid  input  1  qualifies a/b/c this cycle
- sum  output  WIDTH  registered sum bits [WIDTH-1:0]
- carry  output  1  registered carry-out (bit WIDTH of a+b+c)
- out_valid  output  1  registered; high when sum/carry hold a result for an accepted input

Behaviour:
- Per bit i: g[i] = a[i] & b[i]; p[i] = a[i] ^ b[i].
- Within each 4-bit group, carries are computed in lookahead form, not rippled:
  - c1 = g0 | p0&cin
  - c2 = g1 | p1&g0 | p1&p0&cin
  - c3 and c4 follow the same expanded pattern.
- Group signals:
  - group generate GG = g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0
  - group propagate GP = p3&p2&p1&p0
- Group carry-in: group 0 takes c. Group k takes GG[k-1] | GP[k-1]&cin[k-1].
- Bit sum: s[i] = p[i] ^ carry_into_bit[i]. Carry-out = carry out of the last group.
- Arithmetic is unsigned modulo 2^WIDTH. Carry-out set iff a+b+c >= 2^WIDTH. No overflow flag.
- Registers, on rising clk edge:
  - If in_valid=1: sum and carry load the combinational result; out_valid <= 1.
  - If in_valid=0: sum and carry hold their previous value; out_valid <= 0.
- Latency: exactly 1 cycle from inputs sampled to sum/carry/out_valid. Throughput: one add per cycle.
- Reset: while rst=1, sum=0, carry=0 and out_valid=0 immediately, independent of clk. Inputs are ignored during reset.
- Deassertion of rst takes effect at the next rising edge; the first result appears one cycle after the first valid input sampled with rst=0.
- Reset mid-operation: any result not yet captured is discarded.
- Input changes between edges have no effect on the outputs. There is no combinational path from inputs to outputs.
- Must be bit-exact against {carry,sum} = a + b + c for all inputs.

Test Plan:
- WIDTH=4, in_valid=1, a=0001, b=1100, c=1 -> next cycle sum=1110, carry=0, out_valid=1.
- a=0010, b=1111, c=0 -> sum=0001, carry=1.
- a=1010, b=1101, c=1 -> sum=1000, carry=1. Then a=1111, b=1111, c=1 -> sum=1111, carry=1. Then a=1101, b=1101, c=0 -> sum=1010, carry=1.
- Hold:
  - Load a=0101, b=0011, c=0 (sum=1000, carry=0).
  - Then drop in_valid and change the inputs -> sum/carry stay 1000/0; out_valid=0.
- Async reset:
  - With sum=1111, carry=1 held, assert rst between clock edges -> sum=0000, carry=0, out_valid=0 immediately.
  - Release rst -> the next valid add appears one cycle later.
- WIDTH=8:
  - Exhaustive (or random 10k) a, b, c vs. the a+b+c model.
  - Include a=11111111, b=00000000, c=1 -> sum=00000000, carry=1, which checks the full cross-group propagate chain.
